// File: rtl/read_channel_axi_burst.sv
// ---------------------------------------------------------------------------
// read_channel_axi_burst
//
// Cache line-fill read engine. On a miss, it fetches one whole cache line from
// backend memory as a single AXI4 INCR burst. Each beat is streamed to the line
// RAM together with its word index within the line.
//
// If any beat of the burst returns a non-OKAY response, the rest of the burst
// is drained and then re-issued to the same address, up to MAX_RETRY times.
// When the retries run out, read_error pulses for one cycle.
//
// Ports
//   ap_clk, reset            clock (rising edge); asynchronous active-high reset
//   replace_valid            miss request, only looked at while idle
//   replace_addr             line address (byte address bits above LINE_LSB)
//   replace                  busy: high whenever a fill is in progress
//   read_valid/addr/rdata    beat strobe, beat index in the line, beat data
//   read_error               one-cycle pulse: the fill failed after all retries
//   m_axi_ar*                AXI read-address channel (master side)
//   m_axi_r*                 AXI read-data channel (master side)
//
// The backend address must be at least as wide as the front-end address;
// the line address is zero-extended onto the AXI address bus.
// ---------------------------------------------------------------------------
module read_channel_axi_burst #(
    parameter int         CACHE_FRONTEND_ADDR_W = 32,
    parameter int         CACHE_FRONTEND_DATA_W = 32,
    parameter int         CACHE_WORD_OFF_W      = 3,
    parameter int         CACHE_BACKEND_ADDR_W  = 32,
    parameter int         CACHE_BACKEND_DATA_W  = 32,
    parameter int         CACHE_AXI_ID_W        = 1,
    parameter int         CACHE_AXI_ID          = 0,
    parameter logic [3:0] CACHE_AXI_CACHE_MODE  = 4'b0011,
    parameter int         CACHE_AXI_LEN_W       = 8,
    parameter int         MAX_RETRY             = 3,
    localparam int        BYTE_W   = $clog2(CACHE_BACKEND_DATA_W / 8),
    localparam int        BEATS    = (CACHE_FRONTEND_DATA_W << CACHE_WORD_OFF_W) / CACHE_BACKEND_DATA_W,
    localparam int        BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int        LINE_LSB = BYTE_W + $clog2(BEATS),
    localparam int        LINE_W   = CACHE_FRONTEND_ADDR_W - LINE_LSB
) (
    input  logic                            ap_clk,
    input  logic                            reset,
    // cache controller side
    input  logic                            replace_valid,
    input  logic [LINE_W-1:0]               replace_addr,
    output logic                            replace,
    output logic                            read_valid,
    output logic [BEAT_W-1:0]               read_addr,
    output logic [CACHE_BACKEND_DATA_W-1:0] read_rdata,
    output logic                            read_error,
    // AXI read-address channel
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    output logic [CACHE_BACKEND_ADDR_W-1:0] m_axi_araddr,
    output logic [CACHE_AXI_LEN_W-1:0]      m_axi_arlen,
    output logic [2:0]                      m_axi_arsize,
    output logic [1:0]                      m_axi_arburst,
    output logic [CACHE_AXI_ID_W-1:0]       m_axi_arid,
    output logic [3:0]                      m_axi_arcache,
    output logic                            m_axi_arlock,
    output logic [2:0]                      m_axi_arprot,
    output logic [3:0]                      m_axi_arqos,
    // AXI read-data channel
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready,
    input  logic [CACHE_BACKEND_DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rlast
);

    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                            r_state;
    state_t                            w_state_next;
    logic   [LINE_W-1:0]               r_line;
    logic   [BEAT_W-1:0]               r_beat_cnt;
    logic   [RETRY_W-1:0]              r_retry_cnt;
    logic                              r_err;
    logic                              r_read_error;

    logic                              w_start;
    logic                              w_beat_fire;
    logic                              w_beat_err;
    logic                              w_resp_err;
    logic                              w_retry_ok;
    logic                              w_retry;
    logic                              w_fail;
    logic   [CACHE_BACKEND_ADDR_W-1:0] w_araddr;

    assign w_start    = (r_state == S_IDLE) && replace_valid;
    assign w_resp_err = (m_axi_rresp != 2'b00);
    // Error seen on this burst so far, including the beat currently presented.
    assign w_beat_err = r_err | w_resp_err;
    assign w_retry_ok = (r_retry_cnt < RETRY_W'(MAX_RETRY));

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge ap_clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and per-cycle strobes
    // The end of a burst is decided by rlast alone, so a misbehaving slave
    // cannot leave the engine waiting on a beat counter.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_beat_fire  = 1'b0;
        w_retry      = 1'b0;
        w_fail       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (replace_valid) begin
                    w_state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (m_axi_arready) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (m_axi_rvalid) begin
                    w_beat_fire = 1'b1;
                    if (m_axi_rlast) begin
                        if (!w_beat_err) begin
                            w_state_next = S_DONE;
                        end else if (w_retry_ok) begin
                            w_state_next = S_ADDR;
                            w_retry      = 1'b1;
                        end else begin
                            w_state_next = S_DONE;
                            w_fail       = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                // One cycle to cover the line RAM write latency.
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Burst bookkeeping: beat index, retry count, sticky error, failure pulse
    // -----------------------------------------------------------------------
    always_ff @(posedge ap_clk or posedge reset) begin
        if (reset) begin
            r_beat_cnt   <= '0;
            r_retry_cnt  <= '0;
            r_err        <= 1'b0;
            r_read_error <= 1'b0;
        end else begin
            r_read_error <= w_fail;
            if (w_start) begin
                r_beat_cnt  <= '0;
                r_retry_cnt <= '0;
                r_err       <= 1'b0;
            end else if (w_retry) begin
                r_beat_cnt  <= '0;
                r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
                r_err       <= 1'b0;
            end else if (w_beat_fire) begin
                // Saturate so an over-long burst cannot wrap onto word 0.
                if (r_beat_cnt != BEAT_W'(BEATS - 1)) begin
                    r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                end
                if (w_resp_err) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Line address is captured on leaving IDLE and reused unchanged by retries.
    always_ff @(posedge ap_clk) begin
        if (w_start) begin
            r_line <= replace_addr;
        end
    end

    always_comb begin
        w_araddr                                       = '0;
        w_araddr[CACHE_FRONTEND_ADDR_W-1:LINE_LSB]     = r_line;
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign replace       = (r_state != S_IDLE);
    // Once a beat errors, it and every later beat of the burst are withheld.
    assign read_valid    = (r_state == S_DATA) && m_axi_rvalid && !r_err && !w_resp_err;
    assign read_addr     = r_beat_cnt;
    assign read_rdata    = m_axi_rdata;
    assign read_error    = r_read_error;

    assign m_axi_arvalid = (r_state == S_ADDR);
    assign m_axi_araddr  = w_araddr;
    assign m_axi_arlen   = CACHE_AXI_LEN_W'(BEATS - 1);
    assign m_axi_arsize  = 3'(BYTE_W);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arid    = CACHE_AXI_ID_W'(CACHE_AXI_ID);
    assign m_axi_arcache = CACHE_AXI_CACHE_MODE;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'b0000;
    assign m_axi_rready  = (r_state == S_DATA);

endmodule

// File: tb/tb_read_channel_axi_burst.sv
// ---------------------------------------------------------------------------
// Bench for read_channel_axi_burst: a default 32-bit instance (8-beat lines)
// and a 256-bit instance (single-beat lines), driven by directed AXI slave
// steps. Expected beats are queued when a beat is driven and compared when the
// design raises read_valid.
// ---------------------------------------------------------------------------
module tb_read_channel_axi_burst;

    logic ap_clk = 1'b0;
    logic reset  = 1'b1;
    always #5 ap_clk = ~ap_clk;

    // ---- instance A: default parameters ----
    logic        a_replace_valid = 1'b0;
    logic [26:0] a_replace_addr  = '0;
    logic        a_replace, a_read_valid, a_read_error;
    logic [2:0]  a_read_addr;
    logic [31:0] a_read_rdata;
    logic        a_arvalid, a_arready = 1'b0;
    logic [31:0] a_araddr;
    logic [7:0]  a_arlen;
    logic [2:0]  a_arsize;
    logic [1:0]  a_arburst;
    logic [0:0]  a_arid;
    logic [3:0]  a_arcache;
    logic        a_arlock;
    logic [2:0]  a_arprot;
    logic [3:0]  a_arqos;
    logic        a_rvalid = 1'b0, a_rready;
    logic [31:0] a_rdata  = '0;
    logic [1:0]  a_rresp  = '0;
    logic        a_rlast  = 1'b0;

    read_channel_axi_burst u_dut_a (
        .ap_clk(ap_clk), .reset(reset),
        .replace_valid(a_replace_valid), .replace_addr(a_replace_addr),
        .replace(a_replace), .read_valid(a_read_valid), .read_addr(a_read_addr),
        .read_rdata(a_read_rdata), .read_error(a_read_error),
        .m_axi_arvalid(a_arvalid), .m_axi_arready(a_arready), .m_axi_araddr(a_araddr),
        .m_axi_arlen(a_arlen), .m_axi_arsize(a_arsize), .m_axi_arburst(a_arburst),
        .m_axi_arid(a_arid), .m_axi_arcache(a_arcache), .m_axi_arlock(a_arlock),
        .m_axi_arprot(a_arprot), .m_axi_arqos(a_arqos),
        .m_axi_rvalid(a_rvalid), .m_axi_rready(a_rready), .m_axi_rdata(a_rdata),
        .m_axi_rresp(a_rresp), .m_axi_rlast(a_rlast)
    );

    // ---- instance B: 256-bit backend, one beat per line ----
    logic         b_replace_valid = 1'b0;
    logic [26:0]  b_replace_addr  = '0;
    logic         b_replace, b_read_valid, b_read_error;
    logic [0:0]   b_read_addr;
    logic [255:0] b_read_rdata;
    logic         b_arvalid, b_arready = 1'b0;
    logic [31:0]  b_araddr;
    logic [7:0]   b_arlen;
    logic [2:0]   b_arsize;
    logic [1:0]   b_arburst;
    logic [0:0]   b_arid;
    logic [3:0]   b_arcache;
    logic         b_arlock;
    logic [2:0]   b_arprot;
    logic [3:0]   b_arqos;
    logic         b_rvalid = 1'b0, b_rready;
    logic [255:0] b_rdata  = '0;
    logic [1:0]   b_rresp  = '0;
    logic         b_rlast  = 1'b0;

    read_channel_axi_burst #(.CACHE_BACKEND_DATA_W(256)) u_dut_b (
        .ap_clk(ap_clk), .reset(reset),
        .replace_valid(b_replace_valid), .replace_addr(b_replace_addr),
        .replace(b_replace), .read_valid(b_read_valid), .read_addr(b_read_addr),
        .read_rdata(b_read_rdata), .read_error(b_read_error),
        .m_axi_arvalid(b_arvalid), .m_axi_arready(b_arready), .m_axi_araddr(b_araddr),
        .m_axi_arlen(b_arlen), .m_axi_arsize(b_arsize), .m_axi_arburst(b_arburst),
        .m_axi_arid(b_arid), .m_axi_arcache(b_arcache), .m_axi_arlock(b_arlock),
        .m_axi_arprot(b_arprot), .m_axi_arqos(b_arqos),
        .m_axi_rvalid(b_rvalid), .m_axi_rready(b_rready), .m_axi_rdata(b_rdata),
        .m_axi_rresp(b_rresp), .m_axi_rlast(b_rlast)
    );

    // ---- scoreboard and counters ----
    typedef struct {
        int          addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_mon;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   n_valid = 0;
    int   n_rderr_cycles = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor for instance A, sampled on the falling edge.
    always @(negedge ap_clk) begin
        if (a_read_error) n_rderr_cycles++;
        if (a_read_valid) begin
            n_valid++;
            n_cmp++;
            assert (sb_q.size() > 0) else begin
                n_mis++;
                $error("FAIL sb_unexpected: read_valid with read_addr %0d, expected no beat", a_read_addr);
            end
            if (sb_q.size() > 0) begin
                e_mon = sb_q.pop_front();
                chk("sb_read_addr", 256'(a_read_addr), 256'(e_mon.addr));
                chk("sb_read_rdata", 256'(a_read_rdata), 256'(e_mon.data));
            end
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic start_fill(input logic [26:0] line);
        a_replace_addr  = line;
        a_replace_valid = 1'b1;
        tick();
        a_replace_valid = 1'b0;
    endtask

    // Wait for ARVALID, stall ARREADY for 'stall' cycles, then accept.
    task automatic do_ar(input int stall, output logic [31:0] addr);
        for (int k = 0; k < 50 && !a_arvalid; k++) tick();
        chk("ar_arvalid_seen", 256'(a_arvalid), 256'(1));
        addr = a_araddr;
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("ar_hold_arvalid", 256'(a_arvalid), 256'(1));
            chk("ar_hold_araddr", 256'(a_araddr), 256'(addr));
        end
        a_arready = 1'b1;
        tick();
        a_arready = 1'b0;
        chk("ar_dropped", 256'(a_arvalid), 256'(0));
        chk("ar_rready", 256'(a_rready), 256'(1));
    endtask

    task automatic send_beat(input int idx, input logic [31:0] d, input logic [1:0] resp,
                             input logic last, input bit push);
        exp_t e;
        a_rvalid = 1'b1;
        a_rdata  = d;
        a_rresp  = resp;
        a_rlast  = last;
        if (push) begin
            e.addr = idx;
            e.data = d;
            sb_q.push_back(e);
        end
        tick();
    endtask

    // Full burst of n beats; error response on err_beat, or on every beat.
    task automatic do_r(input int n, input int gap, input int err_beat, input logic [1:0] resp,
                        input bit all_err, input logic [31:0] base);
        bit          err = 0;
        logic [1:0]  r;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                a_rvalid = 1'b0;
                tick();
            end
            r = (all_err || i == err_beat) ? resp : 2'b00;
            if (r != 2'b00) err = 1;
            send_beat(i, base + 32'(i), r, (i == n - 1), !err);
        end
        a_rvalid = 1'b0;
        a_rlast  = 1'b0;
        a_rresp  = 2'b00;
    endtask

    task automatic finish_fill(input string tag);
        chk({tag, "_done_busy"}, 256'(a_replace), 256'(1));
        tick();
        chk({tag, "_idle"}, 256'(a_replace), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0]  addr1, addr2;
        int           v0, e0;
        logic [255:0] bdata;

        // ---------------- reset state ----------------
        repeat (2) @(posedge ap_clk);
        #1;
        chk("rst_replace", 256'(a_replace), 256'(0));
        chk("rst_arvalid", 256'(a_arvalid), 256'(0));
        chk("rst_rready", 256'(a_rready), 256'(0));
        chk("rst_read_valid", 256'(a_read_valid), 256'(0));
        chk("rst_read_error", 256'(a_read_error), 256'(0));
        chk("rst_read_addr", 256'(a_read_addr), 256'(0));
        chk("const_arlen", 256'(a_arlen), 256'(7));
        chk("const_arsize", 256'(a_arsize), 256'(2));
        chk("const_arburst", 256'(a_arburst), 256'(1));
        chk("const_arcache", 256'(a_arcache), 256'(3));
        chk("const_arid", 256'(a_arid), 256'(0));
        chk("const_lock_prot_qos", 256'({a_arlock, a_arprot, a_arqos}), 256'(0));
        reset = 1'b0;
        tick();

        // ---------------- 1: clean 8-beat fill ----------------
        v0 = n_valid; e0 = n_rderr_cycles;
        a_replace_addr  = 27'h1234;
        a_replace_valid = 1'b1;
        chk("t1_replace_before_edge", 256'(a_replace), 256'(0));
        tick();
        a_replace_valid = 1'b0;
        chk("t1_replace_rise", 256'(a_replace), 256'(1));
        do_ar(0, addr1);
        chk("t1_araddr", 256'(addr1), 256'(32'h24680));
        do_r(8, 0, -1, 2'b00, 0, 32'h0);
        finish_fill("t1");
        chk("t1_valid_count", 256'(n_valid - v0), 256'(8));
        chk("t1_no_read_error", 256'(n_rderr_cycles - e0), 256'(0));

        // ---------------- 2: AR stall and R gaps ----------------
        v0 = n_valid;
        start_fill(27'h0ABC);
        do_ar(5, addr1);
        chk("t2_araddr", 256'(addr1), 256'(32'h15780));
        do_r(8, 2, -1, 2'b00, 0, 32'h100);
        finish_fill("t2");
        chk("t2_valid_count", 256'(n_valid - v0), 256'(8));

        // ---------------- 3: error on beat 3, clean retry ----------------
        v0 = n_valid; e0 = n_rderr_cycles;
        start_fill(27'h0777);
        do_ar(0, addr1);
        chk("t3_araddr", 256'(addr1), 256'(32'hEEE0));
        do_r(8, 0, 3, 2'b10, 0, 32'h200);
        chk("t3_first_valid_count", 256'(n_valid - v0), 256'(3));
        chk("t3_retry_busy", 256'(a_replace), 256'(1));
        do_ar(0, addr2);
        chk("t3_retry_same_addr", 256'(addr2), 256'(addr1));
        do_r(8, 0, -1, 2'b00, 0, 32'h300);
        finish_fill("t3");
        chk("t3_total_valid", 256'(n_valid - v0), 256'(11));
        chk("t3_no_read_error", 256'(n_rderr_cycles - e0), 256'(0));

        // ---------------- 4: every beat errors, retries exhausted ----------------
        v0 = n_valid; e0 = n_rderr_cycles;
        start_fill(27'h0042);
        for (int k = 0; k < 4; k++) begin
            do_ar(0, addr1);
            chk("t4_araddr", 256'(addr1), 256'(32'h840));
            do_r(8, 0, -1, 2'b11, 1, 32'h400);
        end
        chk("t4_read_error_pulse", 256'(a_read_error), 256'(1));
        finish_fill("t4");
        chk("t4_read_error_cleared", 256'(a_read_error), 256'(0));
        repeat (3) tick();
        chk("t4_no_fifth_ar", 256'(a_arvalid), 256'(0));
        chk("t4_read_error_cycles", 256'(n_rderr_cycles - e0), 256'(1));
        chk("t4_no_valid", 256'(n_valid - v0), 256'(0));

        // ---------------- 5: 256-bit backend, single beat ----------------
        b_replace_addr  = 27'h55;
        b_replace_valid = 1'b1;
        tick();
        b_replace_valid = 1'b0;
        chk("t5_arvalid", 256'(b_arvalid), 256'(1));
        chk("t5_araddr", 256'(b_araddr), 256'(32'hAA0));
        chk("t5_arlen", 256'(b_arlen), 256'(0));
        chk("t5_arsize", 256'(b_arsize), 256'(5));
        b_arready = 1'b1;
        tick();
        b_arready = 1'b0;
        chk("t5_rready", 256'(b_rready), 256'(1));
        bdata    = {8{32'hA5A5_0001}} ^ 256'h1234_5678;
        b_rdata  = bdata;
        b_rresp  = 2'b00;
        b_rlast  = 1'b1;
        b_rvalid = 1'b1;
        #1;
        chk("t5_read_valid", 256'(b_read_valid), 256'(1));
        chk("t5_read_addr", 256'(b_read_addr), 256'(0));
        chk("t5_read_rdata", b_read_rdata, bdata);
        tick();
        b_rvalid = 1'b0;
        b_rlast  = 1'b0;
        chk("t5_done_busy", 256'(b_replace), 256'(1));
        chk("t5_read_error", 256'(b_read_error), 256'(0));
        tick();
        chk("t5_idle", 256'(b_replace), 256'(0));

        // ---------------- 6: reset mid-burst ----------------
        a_replace_addr  = 27'h0333;
        a_replace_valid = 1'b1;
        tick();
        do_ar(0, addr1);
        chk("t6_araddr", 256'(addr1), 256'(32'h6660));
        for (int i = 0; i < 4; i++) send_beat(i, 32'h500 + 32'(i), 2'b00, 1'b0, 1);
        a_rvalid = 1'b1;
        a_rdata  = 32'hDEAD_0004;
        a_rlast  = 1'b0;
        reset    = 1'b1;
        #1;
        chk("t6_rst_replace", 256'(a_replace), 256'(0));
        chk("t6_rst_read_valid", 256'(a_read_valid), 256'(0));
        chk("t6_rst_rready", 256'(a_rready), 256'(0));
        chk("t6_rst_arvalid", 256'(a_arvalid), 256'(0));
        chk("t6_rst_read_addr", 256'(a_read_addr), 256'(0));
        chk("t6_rst_read_error", 256'(a_read_error), 256'(0));
        chk("t6_rst_rdata_follows", 256'(a_read_rdata), 256'(32'hDEAD_0004));
        a_rvalid = 1'b0;
        tick();
        chk("t6_held_in_reset", 256'(a_replace), 256'(0));
        reset = 1'b0;
        v0 = n_valid;
        tick();
        chk("t6_restart", 256'(a_replace), 256'(1));
        a_replace_valid = 1'b0;
        do_ar(0, addr1);
        chk("t6_restart_araddr", 256'(addr1), 256'(32'h6660));
        do_r(8, 0, -1, 2'b00, 0, 32'h600);
        finish_fill("t6");
        chk("t6_valid_count", 256'(n_valid - v0), 256'(8));

        repeat (2) tick();
        chk("sb_drained", 256'(sb_q.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
